// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rx_pkg
//  Purpose  : Shared mode codes, word-format widths and serializer states
//             for the RX stream packer.
//  Revision : 1.0
// ============================================================================
package rx_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_CNT    = 2'd1;
    localparam logic [1:0] MODE_ZERO   = 2'd2;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with a registered head word and full/empty.
//  Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;

    logic [c_cnt_w-1:0] w_mem_cnt;
    logic               w_pop;
    logic               w_push;
    logic               w_to_out;
    logic               w_to_mem;
    logic               w_mem_rd;

    // r_count covers the head register plus the memory behind it
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = ~r_out_valid;
    assign w_pop     = rd_en & r_out_valid;
    assign w_push    = wr_en & (~full | w_pop);
    assign w_mem_cnt = r_count - c_cnt_w'(r_out_valid);
    assign w_mem_rd  = w_pop & (w_mem_cnt != '0);
    assign w_to_out  = w_push & (~r_out_valid | (w_pop & (w_mem_cnt == '0)));
    assign w_to_mem  = w_push & ~w_to_out;

    always_ff @(posedge clk) begin
        if (w_to_mem) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_to_mem) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_mem_rd) begin
                r_out_data <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + c_ptr_w'(1);
            end else if (w_to_out) begin
                r_out_data <= wr_data;
            end
            if (w_mem_rd | w_to_out) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    assign rd_data = r_out_data;

endmodule
`default_nettype wire

// File: rtl/rx_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_stream_packer
//  Purpose  : Serializes multi-channel I/Q sample sets into 32-bit words,
//             buffers them and tracks drop/accept statistics.
//  Revision : 1.0
// ============================================================================
module rx_stream_packer #(
    parameter int NCH   = 2,
    parameter int SW    = 12,
    parameter int DEPTH = 64,
    parameter int BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              clr,
    input  logic              in_ce,
    input  logic [NCH*SW-1:0] in_i,
    input  logic [NCH*SW-1:0] in_q,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [31:0]       ovf_cnt,
    output logic [31:0]       word_cnt,
    output logic              overflow
);

    import rx_pkg::*;

    localparam int c_idx_w  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_bidx_w = (BURST > 1) ? $clog2(BURST) : 1;

    function automatic logic [HALF_W-1:0] sext16(input logic [SW-1:0] v);
        return HALF_W'($signed(v));
    endfunction

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_next;
    logic               w_capture;
    logic               w_set_drop;
    logic               w_wr_load;
    logic               w_from_input;

    logic [NCH*SW-1:0]  r_hold_i;
    logic [NCH*SW-1:0]  r_hold_q;
    logic [1:0]         r_hold_mode;
    logic [SW-1:0]      w_src_i;
    logic [SW-1:0]      w_src_q;
    logic [1:0]         w_src_mode;

    logic               r_wr_valid;
    logic               r_wr_cnt;
    logic [WORD_W-1:0]  r_wr_data;
    logic [WORD_W-1:0]  w_push_data;
    logic [31:0]        r_test_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_fifo_drop;

    logic               r_en_d;
    logic [c_bidx_w-1:0] r_bidx;
    logic [31:0]        r_ovf_cnt;
    logic [31:0]        r_word_cnt;
    logic               r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Channel 0 is loaded straight from the inputs on capture; SHIFT
    // walks the held channels 1..NCH-1.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_capture    = 1'b0;
        w_set_drop   = 1'b0;
        w_wr_load    = 1'b0;
        w_from_input = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_ce && en) begin
                    w_capture    = 1'b1;
                    w_wr_load    = 1'b1;
                    w_from_input = 1'b1;
                    if (NCH > 1) begin
                        w_state_next = ST_SHIFT;
                        w_idx_next   = c_idx_w'(1);
                    end
                end
            end
            ST_SHIFT: begin
                w_set_drop = in_ce & en;
                w_wr_load  = 1'b1;
                if (r_idx == c_idx_w'(NCH - 1)) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + c_idx_w'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        if (w_from_input) begin
            w_src_i    = in_i[SW-1:0];
            w_src_q    = in_q[SW-1:0];
            w_src_mode = mode;
        end else begin
            w_src_i    = r_hold_i[r_idx*SW +: SW];
            w_src_q    = r_hold_q[r_idx*SW +: SW];
            w_src_mode = r_hold_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_i    <= '0;
            r_hold_q    <= '0;
            r_hold_mode <= MODE_NORMAL;
        end else if (w_capture) begin
            r_hold_i    <= in_i;
            r_hold_q    <= in_q;
            r_hold_mode <= mode;
        end
    end

    // Counter words take their value at the cycle they reach the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_cnt   <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= w_wr_load;
            if (w_wr_load) begin
                r_wr_cnt  <= (w_src_mode == MODE_CNT);
                r_wr_data <= (w_src_mode == MODE_ZERO) ? '0
                           : {sext16(w_src_q), sext16(w_src_i)};
            end
        end
    end

    assign w_push_data = r_wr_cnt ? r_test_cnt : r_wr_data;
    assign w_pop       = ~w_empty & out_ready;
    assign w_push_ok   = r_wr_valid & (~w_full | w_pop);
    assign w_fifo_drop = r_wr_valid & ~w_push_ok;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_wr_valid),
        .wr_data (w_push_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign out_valid = ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_test_cnt <= '0;
        end else if (w_push_ok) begin
            r_test_cnt <= r_test_cnt + 32'd1;
        end
    end

    // A rising en restarts burst numbering, taking priority over a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d <= 1'b0;
            r_bidx <= '0;
        end else begin
            r_en_d <= en;
            if (en && !r_en_d) begin
                r_bidx <= '0;
            end else if (w_pop) begin
                r_bidx <= (r_bidx == c_bidx_w'(BURST - 1)) ? '0
                        : r_bidx + c_bidx_w'(1);
            end
        end
    end

    assign out_last = out_valid & (r_bidx == c_bidx_w'(BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt  <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_ovf_cnt  <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ovf_cnt <= r_ovf_cnt + (w_set_drop ? 32'(NCH) : 32'd0)
                       + 32'(w_fifo_drop);
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_set_drop | w_fifo_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ovf_cnt  = r_ovf_cnt;
    assign word_cnt = r_word_cnt;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rx_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_stream_packer
//  Purpose  : Directed and randomized bench for rx_stream_packer against a
//             queue-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_rx_stream_packer;

    localparam int NCH   = 2;
    localparam int SW    = 12;
    localparam int DEPTH = 64;
    localparam int BURST = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              en        = 1'b0;
    logic [1:0]        mode      = 2'd0;
    logic              clr       = 1'b0;
    logic              in_ce     = 1'b0;
    logic [NCH*SW-1:0] in_i      = '0;
    logic [NCH*SW-1:0] in_q      = '0;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_last;
    logic [31:0]       ovf_cnt;
    logic [31:0]       word_cnt;
    logic              overflow;

    rx_stream_packer #(
        .NCH   (NCH),
        .SW    (SW),
        .DEPTH (DEPTH),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .clr       (clr),
        .in_ce     (in_ce),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .ovf_cnt   (ovf_cnt),
        .word_cnt  (word_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: pending channel writes and FIFO contents as queues
    typedef struct packed {
        logic [SW-1:0] i;
        logic [SW-1:0] q;
        logic [1:0]    mode;
    } samp_t;

    samp_t       pend[$];
    logic [31:0] fq[$];
    logic [31:0] popped[$];
    logic [31:0] m_cnt;
    logic [31:0] m_ovf;
    logic [31:0] m_wc;
    int          m_bidx;
    bit          m_ovfl;
    bit          m_prev_en;

    function automatic logic [15:0] to16(input logic [SW-1:0] v);
        int s;
        s = int'(v);
        if (s >= (1 << (SW - 1))) s = s - (1 << SW);
        return s[15:0];
    endfunction

    function automatic logic [31:0] make_word(input samp_t s, input logic [31:0] cnt);
        if (s.mode == 2'd2) return 32'h0;
        if (s.mode == 2'd1) return cnt;
        return {to16(s.q), to16(s.i)};
    endfunction

    task automatic model_reset();
        pend.delete();
        fq.delete();
        m_cnt     = '0;
        m_ovf     = '0;
        m_wc      = '0;
        m_bidx    = 0;
        m_ovfl    = 1'b0;
        m_prev_en = 1'b0;
    endtask

    task automatic model_edge();
        bit    pop, wr, acc, dfull, dset, cap;
        samp_t s;
        pop   = (fq.size() > 0) && out_ready;
        wr    = (pend.size() > 0);
        acc   = wr && ((fq.size() < DEPTH) || pop);
        dfull = wr && !acc;
        dset  = in_ce && en && (pend.size() > 1);
        cap   = in_ce && en && (pend.size() <= 1);
        if (pop) void'(fq.pop_front());
        if (en && !m_prev_en) m_bidx = 0;
        else if (pop) m_bidx = (m_bidx + 1) % BURST;
        m_prev_en = en;
        if (wr) begin
            s = pend.pop_front();
            if (acc) begin
                fq.push_back(make_word(s, m_cnt));
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (cap) begin
            for (int k = 0; k < NCH; k++) begin
                s.i    = in_i[k*SW +: SW];
                s.q    = in_q[k*SW +: SW];
                s.mode = mode;
                pend.push_back(s);
            end
        end
        if (clr) begin
            m_ovf  = '0;
            m_wc   = '0;
            m_ovfl = 1'b0;
        end else begin
            m_ovf  = m_ovf + (dset ? 32'(NCH) : 32'd0) + 32'(dfull);
            m_wc   = m_wc + 32'(pop);
            m_ovfl = m_ovfl | dset | dfull;
        end
    endtask

    task automatic tick();
        bit ev;
        ev = (fq.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev) chk("out_data", out_data, fq[0]);
        chk("out_last", 32'(out_last), 32'(ev && (m_bidx == BURST - 1)));
        chk("ovf_cnt", ovf_cnt, m_ovf);
        chk("word_cnt", word_cnt, m_wc);
        chk("overflow", 32'(overflow), 32'(m_ovfl));
        if (out_valid && out_ready) popped.push_back(out_data);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sets(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                in_i = (NCH*SW)'($urandom());
                in_q = (NCH*SW)'($urandom());
            end
            in_ce = 1'b1;
            tick();
            in_ce = 1'b0;
            tick();
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", ovf_cnt, 32'd0);
        chk("rst_wc", word_cnt, 32'd0);
        chk("rst_ovfl", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Counter mode, back-to-back sets
        en = 1'b1; mode = 2'd1; out_ready = 1'b1;
        send_sets(40, 1'b1);
        repeat (6) tick();
        chk("cnt_nwords", 32'(popped.size()), 32'd80);
        if (popped.size() >= 80) begin
            chk("cnt_first", popped[0], 32'd0);
            chk("cnt_last", popped[79], 32'd79);
        end
        chk("cnt_ovf", ovf_cnt, 32'd0);

        // Directed format and latency
        popped.delete();
        mode  = 2'd0;
        in_i  = 24'h801005;
        in_q  = 24'h7FF003;
        in_ce = 1'b1;
        tick();
        in_ce = 1'b0;
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("fmt_word0", out_data, 32'h0003_0005);
        tick();
        chk("fmt_word1", out_data, 32'h07FF_F801);
        chk("fmt_last1", 32'(out_last), 32'd0);
        repeat (3) tick();

        // Fill to full with the sink stalled, then drain
        clr = 1'b1; tick(); clr = 1'b0;
        out_ready = 1'b0;
        send_sets(40, 1'b1);
        repeat (4) tick();
        chk("full_ovf", ovf_cnt, 32'd16);
        chk("full_ovfl", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (70) tick();
        chk("drain_wc", word_cnt, 32'd64);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Consecutive strobes drop the second set
        clr = 1'b1; tick(); clr = 1'b0;
        in_ce = 1'b1; tick(); tick(); in_ce = 1'b0;
        repeat (5) tick();
        chk("busy_ovf", ovf_cnt, 32'd2);

        // clr wins over a same-cycle drop
        clr = 1'b1; tick(); clr = 1'b0;
        in_ce = 1'b1; tick();
        clr = 1'b1; tick();
        clr = 1'b0; in_ce = 1'b0;
        chk("clr_ovf", ovf_cnt, 32'd0);
        chk("clr_ovfl", 32'(overflow), 32'd0);
        repeat (4) tick();

        // Reset while words are queued
        out_ready = 1'b0;
        send_sets(5, 1'b1);
        repeat (2) tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_wc", word_cnt, 32'd0);
        chk("arst_ovf", ovf_cnt, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_next_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_sets(10, 1'b1);
        repeat (4) tick();

        // Randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 400; c++) begin
                en        = ($urandom_range(0, 15) != 0);
                mode      = 2'($urandom());
                in_ce     = ($urandom_range(0, 2) == 0);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                clr       = ($urandom_range(0, 99) == 0);
                in_i      = (NCH*SW)'($urandom());
                in_q      = (NCH*SW)'($urandom());
                tick();
            end
        end
        in_ce = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (80) tick();
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_stream_packer.md
RX_STREAM_PACKER -- requirements
Module: rx_stream_packer

Interface
REQ-001 Parameter NCH, default 2, number of RX channels (1..4).
REQ-002 Parameter SW, default 12, sample width in bits (8..16).
REQ-003 Parameter DEPTH, default 64, FIFO depth in 32-bit words (power of 2, >=2*BURST).
REQ-004 Parameter BURST, default 16, words per AXI burst (64 bytes).
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  enable sample capture.
REQ-008 mode  in  2  0=normal, 1=counter test, 2=zero, 3=normal.
REQ-009 clr  in  1  synchronous clear of statistics.
REQ-010 in_ce  in  1  sample strobe, one cycle per sample set.
REQ-011 in_i  in  NCH*SW  I samples, channel k at bits [k*SW +: SW].
REQ-012 in_q  in  NCH*SW  Q samples, same packing.
REQ-013 out_data  out  32  packed word.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  downstream accept.
REQ-016 out_last  out  1  last word of a BURST group.
REQ-017 ovf_cnt  out  32  count of dropped words.
REQ-018 word_cnt  out  32  count of words accepted by downstream.
REQ-019 overflow  out  1  sticky drop flag.

Function
REQ-020 Word format SHALL be {sext16(Q), sext16(I)}; mode 2 SHALL emit 32'h0; mode 1 SHALL emit a 32-bit counter incremented per word written to the FIFO, starting at 0 after reset.
REQ-021 Serializer FSM SHALL have states IDLE and SHIFT; in IDLE, in_ce&en captures all NCH pairs into a holding register, writes channel 0 that cycle+1, and moves to SHIFT when NCH>1.
REQ-022 In SHIFT the FSM SHALL write channels 1..NCH-1 one per cycle in ascending order, then return to IDLE.
REQ-023 An in_ce arriving while in SHIFT SHALL be dropped; ovf_cnt SHALL increase by NCH and overflow SHALL set.
REQ-024 A FIFO write while full SHALL be dropped (ovf_cnt +1, overflow set), unless a pop occurs in the same cycle, in which case the write SHALL be accepted.
REQ-025 Simultaneous push and pop on an empty FIFO SHALL not bypass; the word appears on the following cycle.
REQ-026 Latency: with the FIFO empty and out_ready high, channel 0 of an in_ce at cycle t SHALL show out_valid at t+2.
REQ-027 out_data/out_valid SHALL remain stable while out_valid&!out_ready.
REQ-028 out_last SHALL be high on the popped word whose burst index mod BURST = BURST-1; the burst index SHALL reset to 0 on reset and on the rising edge of en.
REQ-029 en falling SHALL block new captures; an in-progress SHIFT SHALL complete, and the FIFO SHALL continue draining.
REQ-030 word_cnt SHALL increment on each out_valid&out_ready; counters SHALL wrap at 2^32.
REQ-031 clr SHALL zero ovf_cnt, word_cnt and overflow without touching FIFO contents, the FSM or the test counter; clr wins over a same-cycle increment.
REQ-032 mode changes SHALL take effect at the next capture, never mid-sample-set.

Reset
REQ-033 On rst_n low: FSM=IDLE, FIFO empty, out_valid=0, out_last=0, out_data=0, ovf_cnt=0, word_cnt=0, overflow=0, test counter=0, burst index=0; an asserted mid-burst reset discards all buffered words.

Structure
REQ-034 Shared package rx_pkg SHALL hold mode constants (MODE_NORMAL, MODE_CNT, MODE_ZERO) and the 16/32-bit word-format widths.
REQ-035 The FIFO SHALL be a separate sub-module sync_fifo (parametrised width/depth, first-word registered output, full/empty flags).

Verification
REQ-036 NCH=2, mode 0, in_i={12'h801,12'h005}, in_q={12'h7FF,12'h003}, one in_ce -> words 32'h0003_0005 then 32'h07FF_F801, the second with out_last=0.
REQ-037 Mode 1, out_ready=1, 40 back-to-back sample sets spaced 2 cycles -> data 0..79 in order, out_last on words 15,31,47,63,79, ovf_cnt=0.
REQ-038 out_ready=0, DEPTH=64, NCH=2, 40 sample sets -> 64 words held, ovf_cnt=16, overflow=1; then out_ready=1 -> 64 words drain, word_cnt=64.
REQ-039 in_ce on two consecutive cycles, NCH=2 -> second set dropped, ovf_cnt=2.
REQ-040 Assert rst_n low mid-burst with 10 words queued -> out_valid=0 on the next cycle, all counters 0, and the first post-reset word has burst index 0.
REQ-041 clr and a drop in the same cycle -> ovf_cnt=0 and overflow=0 after that cycle.
